// File: rtl/lsu_pkg.sv
// Shared encodings, lane widths and FSM state type for the sub-word load/store unit.
package lsu_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational lane insert (store merge) and lane extract with sign/zero extension (load).
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              is_unsigned,
  input  logic [WORD_W-1:0] mem_word,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] merged_c,
  output logic [WORD_W-1:0] extract_c
);

  logic [BYTE_W-1:0] byte_v;
  logic [HALF_W-1:0] half_v;

  always_comb begin
    merged_c  = mem_word;
    extract_c = mem_word;
    byte_v    = mem_word[{lane, 3'b000} +: BYTE_W];
    half_v    = mem_word[{lane[1], 4'b0000} +: HALF_W];
    case (size)
      SZ_BYTE: begin
        merged_c[{lane, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
        extract_c = is_unsigned ? WORD_W'(byte_v)
                                : {{(WORD_W-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
      end
      SZ_HALF: begin
        merged_c[{lane[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
        extract_c = is_unsigned ? WORD_W'(half_v)
                                : {{(WORD_W-HALF_W){half_v[HALF_W-1]}}, half_v};
      end
      default: begin
        // Word and reserved sizes: whole-word pass-through
        merged_c  = wdata;
        extract_c = mem_word;
      end
    endcase
  end

endmodule

// File: rtl/lsu_subword.sv
// Sub-word load/store unit in front of a word-only data memory; byte/half stores use a 2-cycle RMW.
// Optional RMW event counter enabled by defining LSU_RMW_COUNT_EN.
module lsu_subword
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic              stall,
  output logic              misalign,
  output logic [ADDR_W-1:0] dm_address,
  output logic [WORD_W-1:0] dm_write_data,
  output logic              dm_memwrite,
  input  logic [WORD_W-1:0] dm_read_data,
  output logic [CNT_W-1:0]  rmw_count
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] merged_q, merged_d;
  logic [WORD_W-1:0] merged_c, extract_c;
  logic [ADDR_W-1:0] word_addr_c;
  logic              is_word_c, misaligned_c;

  assign word_addr_c  = {addr[ADDR_W-1:2], 2'b00};
  // Reserved size 11 behaves as a word access
  assign is_word_c    = mem_size[1];
  assign misaligned_c = is_word_c ? (addr[1:0] != 2'b00)
                                  : ((mem_size == SZ_HALF) && addr[0]);

  lsu_lane_merge u_lane_merge (
    .size        (mem_size),
    .lane        (addr[1:0]),
    .is_unsigned (mem_unsigned),
    .mem_word    (dm_read_data),
    .wdata       (wdata),
    .merged_c    (merged_c),
    .extract_c   (extract_c)
  );

  always_comb begin
    state_d       = state_q;
    waddr_d       = waddr_q;
    merged_d      = merged_q;
    stall         = 1'b0;
    misalign      = 1'b0;
    dm_memwrite   = 1'b0;
    load_data     = '0;
    dm_address    = word_addr_c;
    dm_write_data = wdata;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (misaligned_c) begin
            misalign = 1'b1;
          end else if (mem_write) begin
            if (is_word_c) begin
              dm_memwrite = 1'b1;
            end else begin
              stall    = 1'b1;
              merged_d = merged_c;
              waddr_d  = word_addr_c;
              state_d  = MERGE;
            end
          end else begin
            load_data = extract_c;
          end
        end
      end
      MERGE: begin
        dm_address    = waddr_q;
        dm_write_data = merged_q;
        dm_memwrite   = 1'b1;
        state_d       = IDLE;
      end
    endcase
    // Reset kills the outputs immediately, aborting any in-flight merge write
    if (!reset_n) begin
      stall       = 1'b0;
      misalign    = 1'b0;
      dm_memwrite = 1'b0;
      load_data   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      waddr_q  <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      merged_q <= merged_d;
    end
  end

`ifdef LSU_RMW_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == IDLE) && (state_d == MERGE)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign rmw_count = cnt_q;
`else
  assign rmw_count = '0;
`endif

endmodule

// File: tb/tb_lsu_subword.sv
// Directed self-checking bench for lsu_subword with a falling-edge word memory model.
module tb_lsu_subword;
  import lsu_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              reset_n;
  logic              mem_read, mem_write, mem_unsigned;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata, load_data, dm_write_data, dm_read_data;
  logic              stall, misalign, dm_memwrite;
  logic [ADDR_W-1:0] dm_address;
  logic [CNT_W-1:0]  rmw_count;

  logic [31:0] mem [0:255];
  int n_pass, n_total, rmw_exp;

  lsu_subword #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock         (clk),
    .reset_n       (reset_n),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_size      (mem_size),
    .mem_unsigned  (mem_unsigned),
    .addr          (addr),
    .wdata         (wdata),
    .load_data     (load_data),
    .stall         (stall),
    .misalign      (misalign),
    .dm_address    (dm_address),
    .dm_write_data (dm_write_data),
    .dm_memwrite   (dm_memwrite),
    .dm_read_data  (dm_read_data),
    .rmw_count     (rmw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: samples address/write on the falling edge, read-first
  always @(negedge clk) begin : mem_model
    logic [31:0] rd;
    rd = mem[dm_address[9:2]];
    if (dm_memwrite) mem[dm_address[9:2]] = dm_write_data;
    dm_read_data <= rd;
  end

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_load;
    logic        exp_mis;
    logic        exp_we;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns; addr = a; wdata = wd;
  endtask

  task automatic sample();
    @(negedge clk); #3;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef LSU_RMW_COUNT_EN
    return 32'(CNT_W'(rmw_exp));
`else
    return 32'd0;
`endif
  endfunction

  task automatic rmw_store(input string nm, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_merged);
    drive(1'b0, 1'b1, sz, 1'b0, a, wd);
    sample();
    chk({nm, " stall"}, 32'(stall), 32'd1);
    chk({nm, " no early write"}, 32'(dm_memwrite), 32'd0);
    next_cycle();
    // Inputs in the merge cycle must be ignored
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0);
    sample();
    chk({nm, " merge we"}, 32'(dm_memwrite), 32'd1);
    chk({nm, " merge data"}, dm_write_data, exp_merged);
    chk({nm, " merge addr"}, dm_address, a & ~32'h3);
    chk({nm, " merge stall"}, 32'(stall), 32'd0);
    next_cycle();
    rmw_exp++;
    chk({nm, " mem"}, mem[a[9:2]], exp_merged);
  endtask

  initial begin
    n_pass = 0; n_total = 0; rmw_exp = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h11223344;
    mem[32'h108 >> 2] = 32'h55667788;
    mem[32'h110 >> 2] = 32'h01020304;

    vecs.push_back('{"ld b 103 s",   1, 0, SZ_BYTE, 0, 32'h103, 0, 32'h00000011, 0, 0});
    vecs.push_back('{"ld b 101 s",   1, 0, SZ_BYTE, 0, 32'h101, 0, 32'h00000033, 0, 0});
    vecs.push_back('{"ld h 102 u",   1, 0, SZ_HALF, 1, 32'h102, 0, 32'h00001122, 0, 0});
    vecs.push_back('{"st w 200",     0, 1, SZ_WORD, 0, 32'h200, 32'h0000FF80, 0, 0, 1});
    vecs.push_back('{"ld h 200 s",   1, 0, SZ_HALF, 0, 32'h200, 0, 32'hFFFFFF80, 0, 0});
    vecs.push_back('{"ld h 200 u",   1, 0, SZ_HALF, 1, 32'h200, 0, 32'h0000FF80, 0, 0});
    vecs.push_back('{"st w 104",     0, 1, SZ_WORD, 0, 32'h104, 32'hDEADBEEF, 0, 0, 1});
    vecs.push_back('{"ld b 104 s",   1, 0, SZ_BYTE, 0, 32'h104, 0, 32'hFFFFFFEF, 0, 0});
    vecs.push_back('{"ld b 107 u",   1, 0, SZ_BYTE, 1, 32'h107, 0, 32'h000000DE, 0, 0});
    vecs.push_back('{"ld h 106 s",   1, 0, SZ_HALF, 0, 32'h106, 0, 32'hFFFFDEAD, 0, 0});
    vecs.push_back('{"ld w 104",     1, 0, SZ_WORD, 0, 32'h104, 0, 32'hDEADBEEF, 0, 0});
    vecs.push_back('{"ld rsv 104",   1, 0, 2'b11,   1, 32'h104, 0, 32'hDEADBEEF, 0, 0});
    vecs.push_back('{"mis ld h 101", 1, 0, SZ_HALF, 0, 32'h101, 0, 32'h0, 1, 0});
    vecs.push_back('{"mis st w 106", 0, 1, SZ_WORD, 0, 32'h106, 32'h12345678, 0, 1, 0});
    vecs.push_back('{"mis ld w 102", 1, 0, SZ_WORD, 0, 32'h102, 0, 32'h0, 1, 0});
    vecs.push_back('{"rd+wr w 10C",  1, 1, SZ_WORD, 0, 32'h10C, 32'h12345678, 0, 0, 1});
    vecs.push_back('{"idle",         0, 0, SZ_WORD, 0, 32'h000, 0, 32'h0, 0, 0});

    // Reset state, with an aligned word store presented during reset
    reset_n = 1'b0;
    drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h104, 32'h12345678);
    #2;
    chk("rst memwrite", 32'(dm_memwrite), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst misalign", 32'(misalign), 32'd0);
    chk("rst load_data", load_data, 32'd0);
    chk("rst rmw_count", 32'(rmw_count), 32'd0);
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].a, vecs[i].wd);
      sample();
      chk({vecs[i].name, " load_data"}, load_data, vecs[i].exp_load);
      chk({vecs[i].name, " misalign"}, 32'(misalign), 32'(vecs[i].exp_mis));
      chk({vecs[i].name, " memwrite"}, 32'(dm_memwrite), 32'(vecs[i].exp_we));
      chk({vecs[i].name, " stall"}, 32'(stall), 32'd0);
      chk({vecs[i].name, " dm_address"}, dm_address, vecs[i].a & ~32'h3);
      if (vecs[i].exp_we) chk({vecs[i].name, " wdata"}, dm_write_data, vecs[i].wd);
      next_cycle();
    end
    chk("mem 104", mem[32'h104 >> 2], 32'hDEADBEEF);
    chk("mem 10C", mem[32'h10C >> 2], 32'h12345678);

    // Byte RMW then back-to-back loads of the merged word
    rmw_store("st b 101", SZ_BYTE, 32'h101, 32'hAAAAAAEE, 32'h1122EE44);
    drive(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0);
    sample();
    chk("b2b ld b 101 u", load_data, 32'h000000EE);
    chk("b2b stall", 32'(stall), 32'd0);
    next_cycle();
    drive(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h100, 32'h0);
    sample();
    chk("ld h 100 s", load_data, 32'hFFFFEE44);
    next_cycle();

    rmw_store("st h 112", SZ_HALF, 32'h112, 32'h1234BEEF, 32'hBEEF0304);
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    sample();
    chk("rmw_count after 2", 32'(rmw_count), exp_cnt());
    next_cycle();

    // Reset asserted while the halfword merge write is pending
    drive(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h108, 32'h0000CAFE);
    sample();
    chk("rst-merge stall", 32'(stall), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    chk("rst-merge we before", 32'(dm_memwrite), 32'd1);
    reset_n = 1'b0;
    rmw_exp = 0;
    #1;
    chk("rst-merge we dropped", 32'(dm_memwrite), 32'd0);
    chk("rst-merge stall", 32'(stall), 32'd0);
    sample();
    chk("rst-merge mem kept", mem[32'h108 >> 2], 32'h55667788);
    chk("rst-merge count", 32'(rmw_count), 32'd0);
    reset_n = 1'b1;
    next_cycle();
    sample();
    chk("post-rst idle we", 32'(dm_memwrite), 32'd0);
    next_cycle();

    // 17 RMW events wrap a 4-bit counter to 1
    for (int i = 1; i <= 17; i++)
      rmw_store("st b 300", SZ_BYTE, 32'h300, 32'(i), 32'(i));
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    sample();
    chk("rmw_count after 17", 32'(rmw_count), exp_cnt());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit between the execute stage (ALU result, Read_data2, control) and the 32-bit word data memory `dmemory32`.
- The data memory writes whole words only, with a single write enable. This block adds byte and halfword loads, each sign- or zero-extended.
- It implements byte and halfword stores as a two-cycle read-modify-write, and stalls the core for one cycle while it does so.
- It also detects misaligned accesses.

Parameters:
- ADDR_W, 32, width of the byte address.
- CNT_W, 16, width of the optional RMW event counter.

Ports:
- clock  in  1  core clock. The data memory samples on its falling edge, so memory read data is valid before the next rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request (from control).
- mem_write  in  1  store request (from control).
- mem_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- addr  in  ADDR_W  byte address (ALU result).
- wdata  in  32  store data (Read_data2); the sub-word is taken from the low bits.
- load_data  out  32  extended load result for writeback.
- stall  out  1  hold PC/pipeline; core keeps all inputs stable while high.
- misalign  out  1  one-cycle pulse on a misaligned request.
- dm_address  out  ADDR_W  to memory address; low 2 bits forced to 00.
- dm_write_data  out  32  to memory dina.
- dm_memwrite  out  1  to memory write enable.
- dm_read_data  in  32  from memory douta.
- rmw_count  out  CNT_W  RMW event counter (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0): state=IDLE; stall=0, misalign=0, dm_memwrite=0, load_data=0, rmw_count=0, merge register=0.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]. Halfword lane = addr[1].
- Misaligned requests:
  - halfword with addr[0]=1, or word with addr[1:0]≠00, is misaligned.
  - Response: misalign=1 for that cycle, dm_memwrite=0, load_data=0, no stall, state stays IDLE.
- Request conflicts:
  - mem_read and mem_write both high: the store wins; load_data=0.
  - Neither high: everything idle, dm_memwrite=0, load_data=0.
- FSM states: IDLE, MERGE.
- IDLE with an aligned load:
  - Single cycle, combinational from dm_read_data.
  - Selected lane is extended per mem_unsigned. Word loads pass through unchanged.
  - stall=0.
- IDLE with an aligned word store: dm_memwrite=1 and dm_write_data=wdata in the same cycle; stall=0; no state change.
- IDLE with an aligned byte or halfword store:
  - dm_memwrite=0 and stall=1.
  - At the rising edge, register merged = dm_read_data with the target lane replaced by wdata[7:0] or wdata[15:0]. Go to MERGE.
- MERGE:
  - dm_address is the word address latched at entry; current inputs are ignored.
  - dm_write_data=merged, dm_memwrite=1, stall=0.
  - Next edge returns to IDLE. The core advances at this edge, so a store takes exactly 2 cycles.
- Back-to-back: a new request in the cycle after MERGE is handled normally from IDLE. No bubble is required beyond the stall.
- reset_n asserted in MERGE: the write is aborted immediately (dm_memwrite falls asynchronously); memory is left unmodified.
- dm_address bits [1:0] are always 00, and stall never exceeds 1 consecutive cycle.

Optional Feature:
- Macro LSU_RMW_COUNT_EN.
- Defined: rmw_count increments by 1 on each IDLE→MERGE transition and wraps at 2^CNT_W−1 → 0. It is cleared by reset.
- Undefined: no counter logic; rmw_count is tied to 0.

Decomposition:
- Shared package `lsu_pkg` holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state typedef (IDLE, MERGE);
  - the lane-width constants.
- One sub-module, `lsu_lane_merge`: combinational lane insert (for stores) and lane extract plus extend (for loads). It is shared by both paths and unit-testable in isolation.

Test Plan:
- Memory word 0x11223344 at 0x100. Byte load addr 0x103 with mem_unsigned=0 → load_data=0x00000011. Byte load addr 0x101 → 0x00000033. Halfword unsigned load at 0x102 → 0x00001122. Store 0x0000FF80 to 0x200, then signed halfword load at 0x200 → 0xFFFFFF80; same address with mem_unsigned=1 → 0x0000FF80.
- Byte store wdata=0xAAAAAAEE to 0x101 over word 0x11223344 → stall high for 1 cycle, then one dm_memwrite pulse with 0x1122EE44; memory reads 0x1122EE44.
- Word store 0xDEADBEEF to 0x104 → dm_memwrite in the same cycle, stall never rises.
- Halfword load at 0x101 and word store at 0x106 → misalign pulses each time, no dm_memwrite, load_data=0.
- reset_n low during MERGE of a halfword store to 0x108 (old value 0x55667788) → dm_memwrite drops immediately, memory still holds 0x55667788, stall=0.
- With LSU_RMW_COUNT_EN and CNT_W=4: 17 byte stores → rmw_count=1 (wrap). Without the macro, rmw_count stays 0.
